// File: rtl/led_ui_pkg.sv
// Shared constants and types for the LED pattern command front-end.
// FSM encoding, default timing parameters and the key event bundle.
package led_ui_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;

  localparam int DB_CYCLES_DEF   = 500000;
  localparam int DB_W_DEF        = 20;
  localparam int AUTO_PERIOD_DEF = 25000000;
  localparam int AP_W_DEF        = 25;

  typedef struct packed {
    logic step;
    logic start;
    logic pause;
  } key_ev_t;

  function automatic logic is_run(input logic [1:0] st);
    return (st == ST_RUN);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: invert, 2-flop synchronize, debounce, and emit a
// one-cycle press event on each accepted release->press change.
module key_debounce
  import led_ui_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int DB_W      = DB_W_DEF
)(
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic pressed,
  output logic press
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0] CNT_ONE  = DB_W'(1);
  localparam logic [DB_W-1:0] CNT_ZERO = DB_W'(0);

  logic            sync1_r;
  logic            sync2_r;
  logic [DB_W-1:0] cnt_r;
  logic            pressed_r;
  logic            press_r;

  // synchronizer, stability counter and debounced level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r   <= 1'b0;
      sync2_r   <= 1'b0;
      cnt_r     <= CNT_ZERO;
      pressed_r <= 1'b0;
      press_r   <= 1'b0;
    end else begin
      sync1_r <= ~key_n;
      sync2_r <= sync1_r;
      press_r <= 1'b0;
      if (sync2_r != pressed_r) begin
        if (cnt_r == CNT_LAST) begin
          pressed_r <= sync2_r;
          cnt_r     <= CNT_ZERO;
          press_r   <= sync2_r;
        end else begin
          cnt_r <= cnt_r + CNT_ONE;
        end
      end else begin
        cnt_r <= CNT_ZERO;
      end
    end
  end

  assign pressed = pressed_r;
  assign press   = press_r;

endmodule

// File: rtl/led_cmd_gen.sv
// Pushbutton command front-end: three debounced keys drive an
// IDLE/RUN/PAUSED FSM, an auto-step timer and registered control pulses.
module led_cmd_gen
  import led_ui_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int DB_W        = DB_W_DEF,
  parameter int AUTO_PERIOD = AUTO_PERIOD_DEF,
  parameter int AP_W        = AP_W_DEF
)(
  input  logic clk,
  input  logic reset,
  input  logic key_step_n,
  input  logic key_start_n,
  input  logic key_pause_n,
  input  logic auto_en,
  output logic step,
  output logic start,
  output logic pause,
  output logic running
);

  localparam logic [AP_W-1:0] AP_LAST = AP_W'(AUTO_PERIOD - 1);
  localparam logic [AP_W-1:0] AP_ONE  = AP_W'(1);
  localparam logic [AP_W-1:0] AP_ZERO = AP_W'(0);

  key_ev_t press_s;
  key_ev_t level_s;
  key_ev_t ev_s;

  logic [1:0]      state_r;
  logic [1:0]      state_nx_s;
  logic [AP_W-1:0] timer_r;
  logic [AP_W-1:0] timer_nx_s;
  logic            auto_on_s;
  logic            auto_req_s;
  logic            step_r;
  logic            start_r;
  logic            pause_r;
  logic            running_r;

  key_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_step (
    .clk(clk), .reset(reset), .key_n(key_step_n),
    .pressed(level_s.step), .press(press_s.step)
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_start (
    .clk(clk), .reset(reset), .key_n(key_start_n),
    .pressed(level_s.start), .press(press_s.start)
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_pause (
    .clk(clk), .reset(reset), .key_n(key_pause_n),
    .pressed(level_s.pause), .press(press_s.pause)
  );

  // a press event is only trusted while its settled level agrees
  assign ev_s = press_s & level_s;

  // next-state logic; start wins over a coincident pause
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ev_s.start) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (ev_s.pause && !ev_s.start) begin
          state_nx_s = ST_PAUSED;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_PAUSED: begin
        if (ev_s.start) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_PAUSED;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  assign auto_on_s  = is_run(state_r) && auto_en;
  assign auto_req_s = auto_on_s && (timer_r == AP_LAST);

  // auto timer restarts on wrap or on a manual step; idles at zero otherwise
  always_comb begin
    timer_nx_s = AP_ZERO;
    if (!auto_on_s) begin
      timer_nx_s = AP_ZERO;
    end else if (ev_s.step || auto_req_s) begin
      timer_nx_s = AP_ZERO;
    end else begin
      timer_nx_s = timer_r + AP_ONE;
    end
  end

  // state, timer and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      timer_r   <= AP_ZERO;
      step_r    <= 1'b0;
      start_r   <= 1'b0;
      pause_r   <= 1'b0;
      running_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      timer_r   <= timer_nx_s;
      step_r    <= (ev_s.step | auto_req_s) & ~step_r;
      start_r   <= is_run(state_nx_s) && !is_run(state_r);
      pause_r   <= is_run(state_r) && (state_nx_s == ST_PAUSED);
      running_r <= is_run(state_nx_s);
    end
  end

  assign step    = step_r;
  assign start   = start_r;
  assign pause   = pause_r;
  assign running = running_r;

endmodule

// File: tb/tb_led_cmd_gen.sv
// Self-checking bench for led_cmd_gen (DB_CYCLES=4, AUTO_PERIOD=8): cycle model,
// table-driven segments, hand-written corner sequences and random key activity.
module tb_led_cmd_gen;

  localparam int DB = 4;
  localparam int AP = 8;
  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSED = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic key_step_n = 1'b1;
  logic key_start_n = 1'b1;
  logic key_pause_n = 1'b1;
  logic auto_en = 1'b0;
  logic step, start, pause, running;

  always #5 clk = ~clk;

  led_cmd_gen #(.DB_CYCLES(DB), .DB_W(4), .AUTO_PERIOD(AP), .AP_W(4)) dut (
    .clk(clk), .reset(reset),
    .key_step_n(key_step_n), .key_start_n(key_start_n), .key_pause_n(key_pause_n),
    .auto_en(auto_en),
    .step(step), .start(start), .pause(pause), .running(running)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference model: keys modelled as delayed samples plus a run-length of disagreement
  int   cyc = 0;
  logic m_s1 [0:2];
  logic m_s2 [0:2];
  logic m_deb [0:2];
  int   m_run [0:2];
  logic m_ev [0:2];
  int   mode;
  int   anchor;
  logic e_step, e_start, e_pause, e_running;

  int cnt_step, cnt_start, cnt_pause;
  int first_step, first_start, tick_no;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_s1[k] = 1'b0; m_s2[k] = 1'b0; m_deb[k] = 1'b0; m_run[k] = 0; m_ev[k] = 1'b0;
    end
    mode = M_IDLE;
    anchor = cyc;
    e_step = 1'b0; e_start = 1'b0; e_pause = 1'b0; e_running = 1'b0;
  endtask

  task automatic model_edge();
    logic raw [0:2];
    logic run_before, fire;
    cyc++;
    if (reset) begin
      model_reset();
    end else begin
      raw[0] = ~key_step_n; raw[1] = ~key_start_n; raw[2] = ~key_pause_n;
      run_before = (mode == M_RUN);
      fire = run_before && auto_en && ((cyc - anchor) == AP);
      if (!(run_before && auto_en) || m_ev[0] || fire) anchor = cyc;
      e_step  = (m_ev[0] || fire) && !e_step;
      e_start = 1'b0;
      e_pause = 1'b0;
      if (m_ev[1]) begin
        if (mode != M_RUN) begin mode = M_RUN; e_start = 1'b1; end
      end else if (m_ev[2] && mode == M_RUN) begin
        mode = M_PAUSED; e_pause = 1'b1;
      end
      e_running = (mode == M_RUN);
      for (int k = 0; k < 3; k++) begin
        m_ev[k] = 1'b0;
        if (m_s2[k] != m_deb[k]) begin
          m_run[k]++;
          if (m_run[k] == DB) begin
            m_deb[k] = ~m_deb[k];
            m_run[k] = 0;
            m_ev[k] = m_deb[k];
          end
        end else begin
          m_run[k] = 0;
        end
        m_s2[k] = m_s1[k];
        m_s1[k] = raw[k];
      end
    end
  endtask

  task automatic check_out(input string name);
    vectors++;
    if ({step, start, pause, running} !== {e_step, e_start, e_pause, e_running}) begin
      miscompares++;
      $display("FAIL %s cyc=%0d step/start/pause/running got %b required %b", name, cyc,
               {step, start, pause, running}, {e_step, e_start, e_pause, e_running});
    end
  endtask

  task automatic expect_eq(input string name, input int got, input int req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  task automatic clear_counts();
    cnt_step = 0; cnt_start = 0; cnt_pause = 0;
    first_step = 0; first_start = 0; tick_no = 0;
  endtask

  // one clock: model advances at the edge, outputs checked at the falling edge
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_out("cycle");
    tick_no++;
    if (step === 1'b1) begin cnt_step++; if (first_step == 0) first_step = tick_no; end
    if (start === 1'b1) begin cnt_start++; if (first_start == 0) first_start = tick_no; end
    if (pause === 1'b1) cnt_pause++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input int hold);
    reset = 1'b1;
    model_reset();
    #1;
    check_out("reset_async");
    expect_eq("reset_outputs", int'({step, start, pause, running}), 0);
    for (int i = 0; i < hold; i++) tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic step_n;
    logic start_n;
    logic pause_n;
    logic aen;
    int   cycles;
    int   n_step;
    int   n_start;
    int   n_pause;
    int   run_end;
  } seg_t;

  seg_t segs [0:15];

  initial begin
    segs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0,  6, 0, 0, 0, 0};
    segs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 10, 1, 0, 0, 0};
    segs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 10, 0, 0, 0, 0};
    segs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 10, 0, 1, 0, 1};
    segs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 10, 0, 0, 0, 1};
    segs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10, 0, 0, 1, 0};
    segs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 10, 0, 0, 0, 0};
    segs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10, 0, 0, 0, 0};
    segs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 10, 0, 0, 0, 0};
    segs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 10, 0, 1, 0, 1};
    segs[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 40, 5, 0, 0, 1};
    segs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 20, 0, 0, 0, 1};
    segs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 10, 0, 0, 1, 0};
    segs[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 10, 0, 0, 0, 0};
    segs[14] = '{1'b1, 1'b0, 1'b1, 1'b1, 20, 1, 1, 0, 1};
    segs[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 10, 0, 0, 0, 1};

    model_reset();
    do_reset(3);

    // press latency and no event on release
    clear_counts();
    key_step_n = 1'b0;
    ticks(10);
    key_step_n = 1'b1;
    ticks(10);
    expect_eq("step_latency", first_step, 7);
    expect_eq("step_single", cnt_step, 1);

    // contact bounce shorter than the debounce window
    clear_counts();
    for (int i = 0; i < 20; i++) begin
      key_step_n = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
    end
    expect_eq("bounce_quiet", cnt_step, 0);
    clear_counts();
    key_step_n = 1'b0;
    ticks(12);
    expect_eq("bounce_settle", cnt_step, 1);
    key_step_n = 1'b1;
    ticks(10);

    // table-driven segments starting from IDLE
    do_reset(2);
    for (int s = 0; s < 16; s++) begin
      clear_counts();
      key_step_n = segs[s].step_n; key_start_n = segs[s].start_n;
      key_pause_n = segs[s].pause_n; auto_en = segs[s].aen;
      ticks(segs[s].cycles);
      expect_eq($sformatf("seg%0d_step", s), cnt_step, segs[s].n_step);
      expect_eq($sformatf("seg%0d_start", s), cnt_start, segs[s].n_start);
      expect_eq($sformatf("seg%0d_pause", s), cnt_pause, segs[s].n_pause);
      expect_eq($sformatf("seg%0d_running", s), int'(running), segs[s].run_end);
    end

    // start and pause accepted together while PAUSED
    key_pause_n = 1'b0; ticks(10);
    key_pause_n = 1'b1; ticks(10);
    clear_counts();
    key_start_n = 1'b0; key_pause_n = 1'b0;
    ticks(10);
    expect_eq("both_start", cnt_start, 1);
    expect_eq("both_pause", cnt_pause, 0);
    expect_eq("both_running", int'(running), 1);
    key_start_n = 1'b1; key_pause_n = 1'b1;
    ticks(10);

    // manual step landing on the auto wrap
    auto_en = 1'b1;
    clear_counts();
    for (int i = 0; i < 20 && cnt_step == 0; i++) tick();
    expect_eq("auto_seen", cnt_step, 1);
    tick();
    key_step_n = 1'b0;
    clear_counts();
    ticks(7);
    expect_eq("coincide_count", cnt_step, 1);
    expect_eq("coincide_when", first_step, 7);
    clear_counts();
    ticks(8);
    expect_eq("after_coincide_count", cnt_step, 1);
    expect_eq("after_coincide_when", first_step, 8);
    key_step_n = 1'b1;

    // reset in the middle of an auto count
    ticks(5);
    do_reset(2);
    auto_en = 1'b0;
    ticks(3);
    expect_eq("post_reset_running", int'(running), 0);

    // key held through reset release
    key_start_n = 1'b0;
    do_reset(3);
    clear_counts();
    ticks(15);
    expect_eq("held_reset_count", cnt_start, 1);
    expect_eq("held_reset_when", first_start, 7);
    key_start_n = 1'b1;
    ticks(10);

    // random key activity against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset(2);
      end else begin
        if ($urandom_range(0, 7) == 0) key_step_n = ~key_step_n;
        if ($urandom_range(0, 9) == 0) key_start_n = ~key_start_n;
        if ($urandom_range(0, 9) == 0) key_pause_n = ~key_pause_n;
        if ($urandom_range(0, 39) == 0) auto_en = ~auto_en;
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_cmd_gen.md
Name: led_cmd_gen

Overview:
- Pushbutton command front-end for the LED pattern state machine on the DE-series board.
- Turns three raw active-low keys into the clean control signals that the LED sequencer consumes:
  - a one-cycle `step` advance pulse;
  - one-cycle `start` and `pause` pulses.
- Adds an optional auto-step timer, so the pattern advances on its own while running.
- Sits between the board KEY pins and the LED sequencer's advance/start/pause inputs; all outputs are registered in the `clk` domain.

Parameters:
- DB_CYCLES, 500000, number of consecutive stable cycles required to accept a key change (10 ms at 50 MHz).
- DB_W, 20, width of the debounce counter; must satisfy 2^DB_W > DB_CYCLES.
- AUTO_PERIOD, 25000000, cycles between auto-step pulses while running (0.5 s at 50 MHz); legal values are >= 2.
- AP_W, 25, width of the auto-step timer; must satisfy 2^AP_W > AUTO_PERIOD.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- key_step_n  input  1  raw step button, active-low, asynchronous to clk
- key_start_n  input  1  raw start button, active-low, asynchronous
- key_pause_n  input  1  raw pause button, active-low, asynchronous
- auto_en  input  1  synchronous level; enables auto-step while RUN
- step  output  1  one-cycle advance pulse to the sequencer
- start  output  1  one-cycle pulse on entry to RUN
- pause  output  1  one-cycle pulse on entry to PAUSED
- running  output  1  level; 1 while the FSM is in RUN

Behaviour:
- Reset (async, active-high):
  - FSM goes to IDLE.
  - step, start, pause and running = 0.
  - Synchronizers, debounce counters and the auto timer clear to 0.
  - Debounced key states clear to "released".
- Per key, input conditioning:
  - Invert the raw input, then pass it through a 2-flop synchronizer.
  - Debounce counter: increments while the synchronized value differs from the debounced state.
  - When the counter reaches DB_CYCLES-1 and the inputs still differ, the debounced state flips and the counter clears.
  - Any cycle in which the synchronized value equals the debounced state clears the counter.
  - Press event = one-cycle pulse when the debounced state goes 0->1. Releases generate no event.
- Latency: a clean raw press asserts its press event 2 + DB_CYCLES cycles after the pin falls; the registered output follows one cycle later.
- FSM states: IDLE, RUN, PAUSED.
  - IDLE: start press -> RUN. Pause press is ignored.
  - RUN: pause press -> PAUSED. Start press is ignored (no pulse).
  - PAUSED: start press -> RUN. Pause press is ignored.
  - Start and pause press in the same cycle: start wins. From IDLE or PAUSED go to RUN; in RUN stay in RUN; no pause pulse.
- start / pause outputs:
  - start = registered pulse exactly in the cycle after an IDLE->RUN or PAUSED->RUN transition.
  - pause = registered pulse in the cycle after a RUN->PAUSED transition.
- running = 1 in the cycle after the FSM enters RUN and for as long as it stays there.
- Auto timer:
  - Counts only while in RUN with auto_en = 1; otherwise holds at 0.
  - On reaching AUTO_PERIOD-1 it requests an auto step and wraps to 0.
- step output:
  - step = registered OR of the step press event (in any state, including IDLE and PAUSED) and the auto-step request.
  - A manual and an auto step in the same cycle produce a single pulse.
  - A manual step while in RUN also restarts the auto timer at 0.
  - step is never asserted on two consecutive cycles.
- Leaving RUN clears the auto timer, so resuming restarts a full AUTO_PERIOD.
- Reset mid-debounce: any partial count is lost.
- Key held through reset release: it is seen as a press after the full debounce interval and generates one event.

Decomposition:
- Package led_ui_pkg holds:
  - FSM state encoding: IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2;
  - default values for DB_CYCLES and AUTO_PERIOD.
- Sub-module key_debounce, instantiated three times:
  - parameters DB_CYCLES and DB_W;
  - ports clk, reset, key_n, pressed (debounced level), press (one-cycle event).
- The top level contains the FSM, the auto timer and the output registers.

Test Plan (DB_CYCLES=4, AUTO_PERIOD=8):
- Reset with all keys released -> all outputs 0. Hold step low for 10 cycles -> exactly one step pulse, 7 cycles after the pin falls; no pulse on release.
- Step pin bouncing low/high every 2 cycles for 20 cycles, then low -> no step pulse during the bounce; exactly one pulse after the final settle.
- Start press from IDLE -> one start pulse, then running = 1. Pause press -> one pause pulse, running = 0. Second pause press -> no pulse. Start press -> start pulse, running = 1.
- RUN with auto_en = 1 for 40 cycles -> step every 8 cycles (5 pulses). Deassert auto_en -> no pulses. Pause then start -> first auto step a full 8 cycles after re-entering RUN.
- Start and pause debounced in the same cycle while in PAUSED -> RUN, start pulse only. Manual step coincident with auto wrap -> single step pulse; next auto step 8 cycles later.
- Assert reset while in RUN mid-count -> outputs 0 and state IDLE immediately. Key held through reset release -> one event after the debounce interval.
